// File: rtl/usb_in_ep_buffer_pkg.sv
// Shared definitions for the USB IN endpoint buffer: FSM state, default packet size, length width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usb_in_ep_buffer_pkg;

  // FILL: application writes the packet. READY: packet is closed and owned by the protocol engine.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } ep_state_t;

  localparam int USB_MAX_PKT = 64;

  // A length counter must represent 0..MAX_PKT inclusive, hence one bit more than the address.
  function automatic int len_width(input int max_pkt);
    return $clog2(max_pkt) + 1;
  endfunction

  localparam int USB_LEN_W = len_width(USB_MAX_PKT);

endpackage

// File: rtl/usb_in_ep_buffer_if.sv
// Bundle of application-side and protocol-engine-side signals of the IN endpoint buffer.
// Latency: n/a (wires only).
// Backpressure: in_ep_data_free throttles the writer; gets beyond the packet length are ignored.
//
// master: the driving side (application + protocol engine together).
// slave : the endpoint buffer itself.
interface usb_in_ep_buffer_if
  import usb_in_ep_buffer_pkg::*;
#(
  parameter int MAX_PKT = USB_MAX_PKT
);

  localparam int LW = len_width(MAX_PKT);

  // Application side
  logic          in_ep_req;
  logic          in_ep_grant;
  logic          in_ep_data_free;
  logic          in_ep_data_put;
  logic [7:0]    in_ep_data;
  logic          in_ep_data_done;
  logic          in_ep_stall;
  logic          in_ep_acked;

  // Protocol engine side
  logic          pe_data_ready;
  logic [LW-1:0] pe_len;
  logic          pe_data_get;
  logic [7:0]    pe_data;
  logic          pe_data_last;
  logic          pe_ack;
  logic          pe_retry;
  logic          pe_stall;

  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    output pe_data_get, pe_ack, pe_retry,
    input  in_ep_grant, in_ep_data_free, in_ep_acked,
    input  pe_data_ready, pe_len, pe_data, pe_data_last, pe_stall
  );

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    input  pe_data_get, pe_ack, pe_retry,
    output in_ep_grant, in_ep_data_free, in_ep_acked,
    output pe_data_ready, pe_len, pe_data, pe_data_last, pe_stall
  );

endinterface

// File: rtl/usb_ep_ram.sv
// Packet byte store: one write port, one registered read port, no reset so it maps onto block RAM.
// Latency: read data valid one cycle after re; rdata holds when re is low.
// Backpressure: none; caller qualifies we/re.
//
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module usb_ep_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_in_ep_buffer.sv
// Single-packet USB IN endpoint buffer between an application writer and the protocol engine.
// Latency: packet ready the cycle after done; read byte valid the cycle after get; stall 1 cycle.
// Backpressure: in_ep_data_free drops when full or not owned; READY blocks the writer until ACK.
//
// Ports: clk, reset (async, active-high), bus (usb_in_ep_buffer_if.slave) carrying the
// application request/put/done/stall/acked signals and the protocol-engine
// ready/len/get/data/last/ack/retry/stall signals.
module usb_in_ep_buffer
  import usb_in_ep_buffer_pkg::*;
#(
  parameter int MAX_PKT = USB_MAX_PKT
) (
  input  logic                 clk,
  input  logic                 reset,
  usb_in_ep_buffer_if.slave    bus
);

  localparam int AW = $clog2(MAX_PKT);
  localparam int LW = len_width(MAX_PKT);

  ep_state_t     state_q, state_d;
  logic [LW-1:0] wr_cnt;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] pe_len_q;
  logic          acked_q;
  logic          last_q;
  logic          stall_q;
  logic          rd_primed;
  logic [7:0]    ram_rdata;

  logic grant;
  logic data_free;
  logic wr_en;
  logic close_pkt;
  logic in_ready;
  logic do_ack;
  logic do_retry;
  logic rd_en;

  // Next state and ownership decode.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_FILL: begin
        grant = bus.in_ep_req;
        if (grant && bus.in_ep_data_done) state_d = ST_READY;
      end
      ST_READY: begin
        in_ready = 1'b1;
        if (bus.pe_ack) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign data_free = grant && (wr_cnt < LW'(MAX_PKT));
  assign wr_en     = data_free && bus.in_ep_data_put;
  assign close_pkt = grant && bus.in_ep_data_done;
  // ACK takes priority over a simultaneous retry; either one suppresses a same-cycle get.
  assign do_ack    = in_ready && bus.pe_ack;
  assign do_retry  = in_ready && bus.pe_retry && !bus.pe_ack;
  assign rd_en     = in_ready && bus.pe_data_get && (rd_ptr < pe_len_q)
                     && !bus.pe_ack && !bus.pe_retry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      pe_len_q  <= '0;
      acked_q   <= 1'b0;
      last_q    <= 1'b0;
      stall_q   <= 1'b0;
      rd_primed <= 1'b0;
    end else begin
      acked_q <= do_ack;
      stall_q <= bus.in_ep_stall;
      if (do_ack) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
        last_q <= 1'b0;
      end else begin
        if (wr_en) wr_cnt <= wr_cnt + LW'(1);
        // A byte put in the same cycle as done belongs to the packet.
        if (close_pkt) pe_len_q <= wr_cnt + LW'(wr_en);
        if (do_retry) begin
          rd_ptr <= '0;
        end else if (rd_en) begin
          rd_ptr    <= rd_ptr + LW'(1);
          last_q    <= (rd_ptr == pe_len_q - LW'(1));
          rd_primed <= 1'b1;
        end
      end
    end
  end

  usb_ep_ram #(
    .DEPTH (MAX_PKT),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.in_ep_data),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; present zero until the first real read after reset.
  assign bus.pe_data         = rd_primed ? ram_rdata : 8'h00;
  assign bus.pe_data_last    = last_q;
  assign bus.pe_len          = pe_len_q;
  assign bus.pe_data_ready   = in_ready;
  assign bus.pe_stall        = stall_q;
  assign bus.in_ep_grant     = grant;
  assign bus.in_ep_data_free = data_free;
  assign bus.in_ep_acked     = acked_q;

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
module tb_usb_in_ep_buffer;

  logic clk;
  logic reset;

  usb_in_ep_buffer_if #(.MAX_PKT(64)) bus();

  usb_in_ep_buffer #(.MAX_PKT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       put;
    logic       done;
    logic [7:0] data;
    logic       exp_grant;
    logic       exp_free;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       chk_last;
  } exp_t;

  vec_t       vt [4];
  exp_t       exp_q [$];
  logic [7:0] mbuf [64];
  int         mcnt;
  int         mlen;
  int         ridx;
  logic [7:0] held_data;
  int         n_cmp;
  int         n_bad;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.in_ep_req       = 1'b0;
    bus.in_ep_data_put  = 1'b0;
    bus.in_ep_data      = 8'h00;
    bus.in_ep_data_done = 1'b0;
    bus.in_ep_stall     = 1'b0;
    bus.pe_data_get     = 1'b0;
    bus.pe_ack          = 1'b0;
    bus.pe_retry        = 1'b0;
  endtask

  // One application cycle; expected grant/free come from the caller's table or model.
  task automatic put_step(input logic req, input logic put, input logic done,
                          input logic [7:0] d, input logic eg, input logic ef);
    bus.in_ep_req       = req;
    bus.in_ep_data_put  = put;
    bus.in_ep_data_done = done;
    bus.in_ep_data      = d;
    #1;
    chk("in_ep_grant", bus.in_ep_grant, eg);
    chk("in_ep_data_free", bus.in_ep_data_free, ef);
    if (put && ef) begin
      mbuf[mcnt] = d;
      mcnt++;
    end
    if (done && eg) begin
      mlen = mcnt;
      ridx = 0;
    end
    tick();
    bus.in_ep_req       = 1'b0;
    bus.in_ep_data_put  = 1'b0;
    bus.in_ep_data_done = 1'b0;
  endtask

  // Issue n consecutive gets; the expectation is queued as each get is driven.
  task automatic do_gets(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      bus.pe_data_get = 1'b1;
      if (ridx < mlen) begin
        e.data     = mbuf[ridx];
        e.last     = (ridx == mlen - 1);
        e.chk_last = 1'b1;
        held_data  = mbuf[ridx];
        ridx++;
      end else begin
        e.data     = held_data;
        e.last     = 1'b0;
        e.chk_last = (mlen == 0);
      end
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      chk("pe_data", {24'h0, bus.pe_data}, {24'h0, e.data});
      if (e.chk_last) chk("pe_data_last", bus.pe_data_last, e.last);
    end
    bus.pe_data_get = 1'b0;
  endtask

  task automatic do_ack(input logic with_retry);
    bus.pe_ack   = 1'b1;
    bus.pe_retry = with_retry;
    tick();
    bus.pe_ack   = 1'b0;
    bus.pe_retry = 1'b0;
    chk("in_ep_acked pulse", bus.in_ep_acked, 1'b1);
    chk("ready after ack", bus.pe_data_ready, 1'b0);
    tick();
    chk("in_ep_acked single", bus.in_ep_acked, 1'b0);
    mcnt = 0;
    mlen = 0;
    ridx = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mcnt  = 0;
    mlen  = 0;
    ridx  = 0;
    held_data = 8'h00;
    clear_inputs();

    vt[0] = '{req: 1'b0, put: 1'b1, done: 1'b0, data: 8'hEE, exp_grant: 1'b0, exp_free: 1'b0};
    vt[1] = '{req: 1'b1, put: 1'b1, done: 1'b0, data: 8'h11, exp_grant: 1'b1, exp_free: 1'b1};
    vt[2] = '{req: 1'b1, put: 1'b1, done: 1'b0, data: 8'h22, exp_grant: 1'b1, exp_free: 1'b1};
    vt[3] = '{req: 1'b1, put: 1'b1, done: 1'b1, data: 8'h33, exp_grant: 1'b1, exp_free: 1'b1};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst grant", bus.in_ep_grant, 1'b0);
    chk("rst free", bus.in_ep_data_free, 1'b0);
    chk("rst acked", bus.in_ep_acked, 1'b0);
    chk("rst ready", bus.pe_data_ready, 1'b0);
    chk("rst pe_data", {24'h0, bus.pe_data}, 32'h0);
    chk("rst last", bus.pe_data_last, 1'b0);
    chk("rst stall", bus.pe_stall, 1'b0);
    chk("rst pe_len", {25'h0, bus.pe_len}, 32'h0);
    reset = 1'b0;
    tick();

    // ACK / retry in FILL are ignored
    bus.pe_ack   = 1'b1;
    bus.pe_retry = 1'b1;
    tick();
    bus.pe_ack   = 1'b0;
    bus.pe_retry = 1'b0;
    chk("ack in FILL", bus.in_ep_acked, 1'b0);
    chk("ready in FILL", bus.pe_data_ready, 1'b0);

    // Three-byte packet from the table, done on the last byte
    for (int i = 0; i < 4; i++)
      put_step(vt[i].req, vt[i].put, vt[i].done, vt[i].data, vt[i].exp_grant, vt[i].exp_free);
    chk("ready 3B", bus.pe_data_ready, 1'b1);
    chk("pe_len 3B", {25'h0, bus.pe_len}, 32'd3);

    // Writer is locked out while READY; buffer and length unchanged
    put_step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("pe_len after READY put", {25'h0, bus.pe_len}, 32'd3);

    // Partial read, rewind, full read plus one surplus get
    do_gets(2);
    bus.pe_retry = 1'b1;
    tick();
    bus.pe_retry = 1'b0;
    ridx = 0;
    chk("ready after retry", bus.pe_data_ready, 1'b1);
    do_gets(4);

    // Stall is a pure one-cycle-delayed echo
    bus.in_ep_stall = 1'b1;
    #1;
    chk("stall before edge", bus.pe_stall, 1'b0);
    tick();
    chk("stall after edge", bus.pe_stall, 1'b1);
    chk("ready with stall", bus.pe_data_ready, 1'b1);
    bus.in_ep_stall = 1'b0;
    tick();
    chk("stall released", bus.pe_stall, 1'b0);

    // ACK wins over simultaneous retry
    do_ack(1'b1);
    chk("last cleared by ack", bus.pe_data_last, 1'b0);

    // Zero-length packet
    put_step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("ready 0B", bus.pe_data_ready, 1'b1);
    chk("pe_len 0B", {25'h0, bus.pe_len}, 32'd0);
    do_gets(2);
    do_ack(1'b0);

    // Full 64-byte packet, overflow put, then done
    for (int i = 0; i < 64; i++)
      put_step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 1'b1, (mcnt < 64));
    put_step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    put_step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("ready 64B", bus.pe_data_ready, 1'b1);
    chk("pe_len 64B", {25'h0, bus.pe_len}, 32'd64);
    do_gets(65);
    do_ack(1'b0);

    // Reset while READY discards the packet asynchronously
    put_step(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    put_step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    chk("ready before reset", bus.pe_data_ready, 1'b1);
    bus.in_ep_stall = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("ready under reset", bus.pe_data_ready, 1'b0);
    chk("pe_len under reset", {25'h0, bus.pe_len}, 32'd0);
    chk("pe_data under reset", {24'h0, bus.pe_data}, 32'h0);
    chk("stall under reset", bus.pe_stall, 1'b0);
    bus.in_ep_stall = 1'b0;
    tick();
    reset = 1'b0;
    mcnt = 0;
    mlen = 0;
    ridx = 0;
    tick();
    put_step(1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);
    chk("pe_len after reset", {25'h0, bus.pe_len}, 32'd1);
    do_gets(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
